// File: rtl/enigma_stream_driver.sv
// enigma_stream_driver: host-side master for the enigma core load/encrypt port.
// One session loads rotorA, rotorB and plugboard tables and then streams code words
// through the core. Results return through a small credit-guarded FIFO.
// Handshake rule for tbl_*, txt_* and res_*: a transfer happens on the rising clk edge
// where valid and ready are both high; ready never waits for valid, and the source may
// change its payload freely once the transfer edge has passed.
module enigma_stream_driver #(
  parameter int ROT_LEN    = 64,
  parameter int PLUG_LEN   = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int CORE_LAT   = 2
) (
  input  logic       clk,
  input  logic       srst_n,
  input  logic       start,
  input  logic       mode,
  input  logic       tbl_valid,
  input  logic [5:0] tbl_data,
  output logic       tbl_ready,
  input  logic       txt_valid,
  input  logic [5:0] txt_data,
  input  logic       txt_last,
  output logic       txt_ready,
  output logic       en_load,
  output logic       en_encrypt,
  output logic       en_crypt_mode,
  output logic [1:0] en_table_idx,
  output logic [5:0] en_code_in,
  input  logic [5:0] en_code_out,
  input  logic       en_code_valid,
  output logic       res_valid,
  output logic [5:0] res_data,
  output logic       res_last,
  input  logic       res_ready,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [2:0] fsm_state
);

  localparam int LEN_MAX = (ROT_LEN > PLUG_LEN) ? ROT_LEN : PLUG_LEN;
  localparam int CNT_W   = (LEN_MAX > 1) ? $clog2(LEN_MAX) : 1;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int INF_W   = $clog2(CORE_LAT + 2);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    LOAD_P = 3'd3,
    RUN    = 3'd4,
    DRAIN  = 3'd5
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   entry_cnt;
  logic               entry_end;
  logic               mode_q;
  logic [INF_W-1:0]   inflight;
  logic               en_last;
  logic [CORE_LAT-1:0] last_sr;
  logic [6:0]         fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]     wr_ptr;
  logic [PTR_W:0]     rd_ptr;
  logic [PTR_W:0]     fifo_count;
  logic [PTR_W:0]     free_slots;
  logic               fifo_empty;
  logic               fifo_full;
  logic               tbl_acc;
  logic               txt_acc;
  logic               cv_ok;
  logic               push;
  logic               pop;
  logic               overflow;
  logic [1:0]         load_idx;

  assign fsm_state  = state;
  assign busy       = (state != IDLE);
  assign tbl_ready  = (state == LOAD_A) || (state == LOAD_B) || (state == LOAD_P);
  assign fifo_count = wr_ptr - rd_ptr;
  assign free_slots = (PTR_W + 1)'(FIFO_DEPTH) - fifo_count;
  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == (PTR_W + 1)'(FIFO_DEPTH));
  // A word is only admitted when a FIFO slot is already reserved for every word in the core.
  assign txt_ready  = (state == RUN) && (8'(free_slots) > 8'(inflight));
  assign tbl_acc    = tbl_valid && tbl_ready;
  assign txt_acc    = txt_valid && txt_ready;
  assign entry_end  = (state == LOAD_P) ? (entry_cnt == CNT_W'(PLUG_LEN - 1))
                                        : (entry_cnt == CNT_W'(ROT_LEN - 1));
  // Core results are only accepted for words actually in flight; strays are flagged and dropped.
  assign cv_ok      = en_code_valid && (inflight != '0);
  assign pop        = res_valid && res_ready;
  assign overflow   = cv_ok && fifo_full && !pop;
  assign push       = cv_ok && !overflow;
  assign res_valid  = !fifo_empty;
  assign res_data   = fifo_empty ? 6'd0 : fifo_mem[rd_ptr[PTR_W-1:0]][5:0];
  assign res_last   = fifo_empty ? 1'b0 : fifo_mem[rd_ptr[PTR_W-1:0]][6];

  // Next-state decode; done marks the cycle DRAIN hands back to IDLE.
  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    load_idx  = 2'b00;
    case (state)
      IDLE:   if (start) state_nxt = LOAD_A;
      LOAD_A: if (tbl_acc && entry_end) state_nxt = LOAD_B;
      LOAD_B: begin
        load_idx = 2'b01;
        if (tbl_acc && entry_end) state_nxt = LOAD_P;
      end
      LOAD_P: begin
        load_idx = 2'b10;
        if (tbl_acc && entry_end) state_nxt = RUN;
      end
      RUN:    if (txt_acc && txt_last) state_nxt = DRAIN;
      DRAIN: begin
        if ((inflight == '0) && fifo_empty) begin
          state_nxt = IDLE;
          done      = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!srst_n) state <= IDLE;
    else         state <= state_nxt;
  end

  // Table entry counter restarts on every state change; session mode is latched on start.
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      entry_cnt <= '0;
      mode_q    <= 1'b0;
    end else begin
      if (state != state_nxt) entry_cnt <= '0;
      else if (tbl_acc)       entry_cnt <= entry_cnt + CNT_W'(1);
      if ((state == IDLE) && start) mode_q <= mode;
    end
  end

  // Registered core port: each accepted symbol or word is presented for exactly one cycle.
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      en_load       <= 1'b0;
      en_encrypt    <= 1'b0;
      en_crypt_mode <= 1'b0;
      en_table_idx  <= 2'b00;
      en_code_in    <= 6'd0;
      en_last       <= 1'b0;
    end else begin
      en_load       <= tbl_acc;
      en_encrypt    <= txt_acc;
      en_crypt_mode <= txt_acc ? mode_q : 1'b0;
      en_table_idx  <= tbl_acc ? load_idx : 2'b00;
      en_code_in    <= tbl_acc ? tbl_data : (txt_acc ? txt_data : 6'd0);
      en_last       <= txt_acc && txt_last;
    end
  end

  // Last-flag delay line matching the core latency, so it lines up with en_code_valid.
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      last_sr <= '0;
    end else begin
      last_sr[0] <= en_last;
      for (int i = 1; i < CORE_LAT; i++) last_sr[i] <= last_sr[i-1];
    end
  end

  // Words in flight: counted from acceptance until the core hands the result back.
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      inflight <= '0;
    end else begin
      case ({txt_acc, cv_ok})
        2'b10:   inflight <= inflight + INF_W'(1);
        2'b01:   inflight <= inflight - INF_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  // Result FIFO pointers; pointers carry one extra wrap bit to tell full from empty.
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (PTR_W + 1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (PTR_W + 1)'(1);
    end
  end

  // Result FIFO storage; contents are don't-care while empty, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[PTR_W-1:0]] <= {last_sr[CORE_LAT-1], en_code_out};
  end

  // Sticky error: stray core result or an overflowing push.
  always_ff @(posedge clk) begin
    if (!srst_n) err <= 1'b0;
    else if ((en_code_valid && (inflight == '0)) || overflow) err <= 1'b1;
  end

endmodule

// File: tb/tb_enigma_stream_driver.sv
// Bench for enigma_stream_driver: a behavioural enigma core, per-cycle port checks,
// a result scoreboard, vector table for the identity session and directed corner cases.
module tb_enigma_stream_driver;

  logic       clk;
  logic       srst_n;
  logic       start;
  logic       mode;
  logic       tbl_valid;
  logic [5:0] tbl_data;
  logic       tbl_ready;
  logic       txt_valid;
  logic [5:0] txt_data;
  logic       txt_last;
  logic       txt_ready;
  logic       en_load;
  logic       en_encrypt;
  logic       en_crypt_mode;
  logic [1:0] en_table_idx;
  logic [5:0] en_code_in;
  logic [5:0] en_code_out;
  logic       en_code_valid;
  logic       res_valid;
  logic [5:0] res_data;
  logic       res_last;
  logic       res_ready;
  logic       busy;
  logic       done;
  logic       err;
  logic [2:0] fsm_state;

  enigma_stream_driver #(
    .ROT_LEN(64), .PLUG_LEN(64), .FIFO_DEPTH(4), .CORE_LAT(2)
  ) dut (
    .clk(clk), .srst_n(srst_n), .start(start), .mode(mode),
    .tbl_valid(tbl_valid), .tbl_data(tbl_data), .tbl_ready(tbl_ready),
    .txt_valid(txt_valid), .txt_data(txt_data), .txt_last(txt_last), .txt_ready(txt_ready),
    .en_load(en_load), .en_encrypt(en_encrypt), .en_crypt_mode(en_crypt_mode),
    .en_table_idx(en_table_idx), .en_code_in(en_code_in),
    .en_code_out(en_code_out), .en_code_valid(en_code_valid),
    .res_valid(res_valid), .res_data(res_data), .res_last(res_last), .res_ready(res_ready),
    .busy(busy), .done(done), .err(err), .fsm_state(fsm_state)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Behavioural enigma core: three table lookups offset by a stepping position.
  logic       force_cv;
  logic       core_clr;
  logic [5:0] core_tab [3][64];
  int         core_ld_cnt [3];
  logic [5:0] core_pos;
  logic       pv1, pv2;
  logic [5:0] pd1, pd2;

  function automatic logic [5:0] core_inv(input int t, input logic [5:0] y);
    logic [5:0] r;
    r = 6'd0;
    for (int i = 0; i < 64; i++) if (core_tab[t][i] == y) r = 6'(i);
    return r;
  endfunction

  function automatic logic [5:0] core_enc(input logic [5:0] x, input logic [5:0] pos);
    logic [5:0] s;
    s = x + pos;
    return core_tab[2][core_tab[1][core_tab[0][s]]];
  endfunction

  function automatic logic [5:0] core_dec(input logic [5:0] x, input logic [5:0] pos);
    return core_inv(0, core_inv(1, core_inv(2, x))) - pos;
  endfunction

  always @(posedge clk) begin
    if (!srst_n) begin
      pv1 <= 1'b0; pv2 <= 1'b0; pd1 <= 6'd0; pd2 <= 6'd0; core_pos <= 6'd0;
      for (int t = 0; t < 3; t++) core_ld_cnt[t] <= 0;
    end else begin
      if (core_clr) begin
        for (int t = 0; t < 3; t++) core_ld_cnt[t] <= 0;
      end else if (en_load && en_table_idx != 2'd3) begin
        if (core_ld_cnt[en_table_idx] < 64) core_tab[en_table_idx][core_ld_cnt[en_table_idx]] <= en_code_in;
        core_ld_cnt[en_table_idx] <= core_ld_cnt[en_table_idx] + 1;
      end
      if (en_load) core_pos <= 6'd0;
      else if (en_encrypt) core_pos <= core_pos + 6'd1;
      pv1 <= en_encrypt;
      pd1 <= en_crypt_mode ? core_dec(en_code_in, core_pos) : core_enc(en_code_in, core_pos);
      pv2 <= pv1;
      pd2 <= pd1;
    end
  end

  assign en_code_valid = pv2 | force_cv;
  assign en_code_out   = pv2 ? pd2 : 6'd0;

  // Scoreboard and bench state
  typedef struct {
    logic [5:0] data;
    logic       last;
    logic [5:0] exp_data;
    logic       exp_last;
  } vec_t;

  vec_t       vecs [5];
  logic [6:0] exp_q [$];
  logic [5:0] got_q [$];
  int         n_vec = 0;
  int         n_err = 0;
  logic       p_load = 1'b0;
  logic       p_enc = 1'b0;
  logic       p_mode = 1'b0;
  logic [1:0] p_idx = 2'b00;
  logic [5:0] p_code = 6'd0;
  int         tbl_cnt = 0;
  logic       sess_mode = 1'b0;
  logic       tbl_acc = 1'b0;
  logic       txt_acc = 1'b0;
  int         done_cnt = 0;
  logic [5:0] src [3][64];
  logic [5:0] pt [8];
  logic [5:0] ct [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] ref_enc(input logic [5:0] x, input int pos);
    logic [5:0] s;
    s = x + 6'(pos);
    return src[2][src[1][src[0][s]]];
  endfunction

  // Per-cycle observation at the falling edge: checks the registered core port against the
  // handshake seen one cycle earlier, records new handshakes, and scores popped results.
  task automatic monitor();
    logic [6:0] e;
    check("en_load", en_load, p_load);
    check("en_encrypt", en_encrypt, p_enc);
    check("en_code_in", en_code_in, p_code);
    if (p_load) check("en_table_idx", en_table_idx, p_idx);
    if (p_enc)  check("en_crypt_mode", en_crypt_mode, p_mode);
    if (!srst_n) tbl_cnt = 0;
    p_load = srst_n && tbl_valid && tbl_ready;
    p_enc  = srst_n && txt_valid && txt_ready;
    p_idx  = 2'(tbl_cnt / 64);
    p_code = p_load ? tbl_data : (p_enc ? txt_data : 6'd0);
    p_mode = sess_mode;
    if (p_load) tbl_cnt++;
    tbl_acc = p_load;
    txt_acc = p_enc;
    if (srst_n && res_valid && res_ready) begin
      got_q.push_back(res_data);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL res_unexpected: got %0h expected none at %0t", res_data, $time);
      end else begin
        e = exp_q.pop_front();
        check("res_data", res_data, e[5:0]);
        check("res_last", res_last, e[6]);
      end
    end
    if (srst_n && done) done_cnt++;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  // Driver tasks
  task automatic send_tbl(input logic [5:0] d);
    int n;
    n = 0;
    tbl_valid = 1'b1;
    tbl_data  = d;
    do begin
      tick();
      n++;
    end while (!tbl_acc && n < 50);
    check("tbl_accept", tbl_acc, 1);
  endtask

  task automatic send_txt(input logic [5:0] d, input logic last, input logic [5:0] expd,
                          input int budget, output bit ok);
    int n;
    n = 0;
    txt_valid = 1'b1;
    txt_data  = d;
    txt_last  = last;
    do begin
      tick();
      n++;
    end while (!txt_acc && n < budget);
    ok = txt_acc;
    if (ok) begin
      txt_valid = 1'b0;
      txt_data  = 6'd0;
      txt_last  = 1'b0;
      exp_q.push_back({last, expd});
    end
  endtask

  task automatic send_ok(input logic [5:0] d, input logic last, input logic [5:0] expd);
    bit ok;
    repeat ($urandom_range(0, 2)) tick();
    send_txt(d, last, expd, 100, ok);
    check("txt_accept", ok, 1);
  endtask

  task automatic start_session(input logic m);
    core_clr = 1'b1;
    tick();
    core_clr  = 1'b0;
    tbl_cnt   = 0;
    done_cnt  = 0;
    sess_mode = m;
    got_q.delete();
    start = 1'b1;
    mode  = m;
    tick();
    start = 1'b0;
    mode  = 1'b0;
    check("busy_after_start", busy, 1);
    check("state_load_a", fsm_state, 1);
  endtask

  task automatic load_tables();
    int bad;
    for (int t = 0; t < 3; t++)
      for (int i = 0; i < 64; i++) send_tbl(src[t][i]);
    tbl_valid = 1'b0;
    tbl_data  = 6'd0;
    check("tbl_ready_after_load", tbl_ready, 0);
    check("state_run", fsm_state, 4);
    repeat (2) tick();
    bad = 0;
    for (int t = 0; t < 3; t++) begin
      check("core_load_count", core_ld_cnt[t], 64);
      for (int i = 0; i < 64; i++) if (core_tab[t][i] !== src[t][i]) bad++;
    end
    check("core_tables", bad, 0);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    check("idle_reached", busy, 0);
  endtask

  task automatic check_all_zero();
    check("z_tbl_ready", tbl_ready, 0);
    check("z_txt_ready", txt_ready, 0);
    check("z_en_load", en_load, 0);
    check("z_en_encrypt", en_encrypt, 0);
    check("z_en_crypt_mode", en_crypt_mode, 0);
    check("z_en_table_idx", en_table_idx, 0);
    check("z_en_code_in", en_code_in, 0);
    check("z_res_valid", res_valid, 0);
    check("z_res_data", res_data, 0);
    check("z_res_last", res_last, 0);
    check("z_busy", busy, 0);
    check("z_done", done, 0);
    check("z_err", err, 0);
    check("z_state", fsm_state, 0);
  endtask

  task automatic shuffle_tables();
    int j;
    logic [5:0] tmp;
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 64; i++) src[t][i] = 6'(i);
      for (int i = 63; i > 0; i--) begin
        j = $urandom_range(0, i);
        tmp = src[t][i];
        src[t][i] = src[t][j];
        src[t][j] = tmp;
      end
    end
  endtask

  // Test sequence
  initial begin
    bit ok;
    // Identity tables: the core adds its step position, so word k (k=0..4) comes back as w+k.
    vecs[0] = '{6'd1, 1'b0, 6'd1, 1'b0};
    vecs[1] = '{6'd2, 1'b0, 6'd3, 1'b0};
    vecs[2] = '{6'd3, 1'b0, 6'd5, 1'b0};
    vecs[3] = '{6'd4, 1'b0, 6'd7, 1'b0};
    vecs[4] = '{6'd5, 1'b1, 6'd9, 1'b1};

    srst_n = 1'b0; start = 1'b0; mode = 1'b0;
    tbl_valid = 1'b0; tbl_data = 6'd0;
    txt_valid = 1'b0; txt_data = 6'd0; txt_last = 1'b0;
    res_ready = 1'b1; force_cv = 1'b0; core_clr = 1'b0;
    repeat (3) tick();
    check_all_zero();
    srst_n = 1'b1;
    tick();

    // Session 1: identity tables, encrypt, vector table
    for (int t = 0; t < 3; t++)
      for (int i = 0; i < 64; i++) src[t][i] = 6'(i);
    start_session(1'b0);
    load_tables();
    for (int i = 0; i < 5; i++) send_ok(vecs[i].data, vecs[i].last, vecs[i].exp_data);
    check("state_drain_or_idle", (fsm_state == 5 || fsm_state == 0), 1);
    wait_idle(100);
    check("s1_done_pulses", done_cnt, 1);
    check("s1_all_results", exp_q.size(), 0);
    check("s1_err", err, 0);

    // Session 2: output stalled, credits cap acceptance at the FIFO depth
    start_session(1'b0);
    load_tables();
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_ok(6'(10 + i), 1'b0, 6'(10 + 2 * i));
    send_txt(6'd14, 1'b0, 6'd18, 20, ok);
    check("stall_accept", ok, 0);
    check("stall_txt_ready", txt_ready, 0);
    check("stall_res_valid", res_valid, 1);
    check("stall_pending", exp_q.size(), 4);
    check("stall_err", err, 0);
    res_ready = 1'b1;
    send_txt(6'd14, 1'b0, 6'd18, 100, ok);
    check("release_accept", ok, 1);
    for (int i = 5; i < 8; i++) send_ok(6'(10 + i), (i == 7), 6'(10 + 2 * i));
    wait_idle(100);
    check("s2_done_pulses", done_cnt, 1);
    check("s2_all_results", exp_q.size(), 0);
    check("s2_err", err, 0);

    // Stray core result while idle sets a sticky error
    force_cv = 1'b1;
    tick();
    force_cv = 1'b0;
    tick();
    check("err_set", err, 1);
    repeat (5) tick();
    check("err_sticky", err, 1);
    check("err_idle", busy, 0);
    srst_n = 1'b0;
    tick();
    srst_n = 1'b1;
    check("err_cleared", err, 0);
    tick();

    // Reset during LOAD_B at entry 10, then a full reload
    shuffle_tables();
    start_session(1'b0);
    for (int i = 0; i < 64; i++) send_tbl(src[0][i]);
    for (int i = 0; i < 10; i++) send_tbl(src[1][i]);
    check("midrst_state", fsm_state, 2);
    tbl_data = src[1][10];
    srst_n = 1'b0;
    tick();
    check_all_zero();
    srst_n = 1'b1;
    tbl_valid = 1'b0;
    tick();
    check("midrst_stays_idle", fsm_state, 0);
    check("midrst_no_done", done_cnt, 0);
    start_session(1'b0);
    load_tables();
    for (int i = 0; i < 8; i++) begin
      pt[i] = 6'($urandom_range(0, 63));
      send_ok(pt[i], (i == 7), ref_enc(pt[i], i));
    end
    wait_idle(100);
    check("enc_done_pulses", done_cnt, 1);
    check("enc_result_count", got_q.size(), 8);
    for (int i = 0; i < 8; i++) ct[i] = (i < got_q.size()) ? got_q[i] : 6'd0;

    // Decrypt session recovers the plaintext
    start_session(1'b1);
    load_tables();
    for (int i = 0; i < 8; i++) send_ok(ct[i], (i == 7), pt[i]);
    wait_idle(100);
    check("dec_done_pulses", done_cnt, 1);
    check("dec_all_results", exp_q.size(), 0);
    check("dec_err", err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
